fp32_mul_round: RTL and testbench
=================================

Name: fp32_mul_round

Overview:
- Downstream stage of the FP32 multiply datapath; consumes the raw 48-bit significand product (24x24 integer multiply) plus the pre-computed sign and exponent sum.
- Normalizes, rounds to nearest-even, detects overflow/underflow, handles special operands, and packs an IEEE-754 single.
- Two-stage pipeline with valid/ready handshake on both sides; throughput 1 result/cycle.

Parameters:
- IN_EXP_W, 10, width of signed input exponent sum (ea + eb - 127, two's complement).
- NAN_CANON, 32'h7FC00000, encoding emitted for any NaN result.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous to clk, active-high
- in_valid  in  1  input operand bundle valid
- in_ready  out  1  stage can accept input this cycle
- in_sign  in  1  product sign (sa ^ sb)
- in_exp  in  IN_EXP_W  signed biased exponent sum, ea + eb - 127
- in_prod  in  48  significand product; binary point between bits 46 and 45
- in_is_nan  in  1  result must be NaN (upstream already folded in inf*0)
- in_is_inf  in  1  result is infinity
- in_is_zero  in  1  result is zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  packed FP32 result
- out_overflow  out  1  overflow flag
- out_underflow  out  1  underflow flag (flush-to-zero)
- out_inexact  out  1  inexact flag

Behaviour:
- Reset: s1_valid = s2_valid = 0; out_valid = 0; out_result = 0; all flags = 0. Applies mid-operation: in-flight data discarded, no output produced for it.
- Handshake: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational back-propagation allowed). Transfer on valid & ready. Outputs stable while out_valid & !out_ready.
- Latency: 2 cycles from accepted input to out_valid with out_ready held high.
- Stage 1 (normalize):
  - in_prod[47] = 1 -> mant = prod[46:24], g = prod[23], s = |prod[22:0], e = in_exp + 1.
  - Otherwise -> mant = prod[45:23], g = prod[22], s = |prod[21:0], e = in_exp.
  - in_prod[47:46] = 0 with no special flag -> treat as zero.
  - Register sign, mant, g, s, e (IN_EXP_W + 1 bits), and the special class.
- Stage 2 (round/pack):
  - Round up iff g & (s | mant[0]). A carry out of 23 bits gives mant = 0, e += 1.
  - e >= 255 -> {sign, 8'hFF, 0}; overflow = 1, inexact = 1.
  - e <= 0 -> {sign, 31'b0}; underflow = 1, inexact = 1. No subnormal outputs (FTZ).
  - Otherwise -> {sign, e[7:0], mant}; inexact = g | s.
  - Special priority: nan > inf > zero > normal.
    - nan -> NAN_CANON.
    - inf -> {sign, 8'hFF, 0}.
    - zero -> {sign, 31'b0}.
    - All three specials clear every flag.
- Overflow/underflow checks use the post-rounding exponent.

Decomposition:
- Package fpu_pkg: fp32_t struct (sign, exp[7:0], frac[22:0]), FP32_BIAS = 127, FP32_EXP_MAX = 255, FP32_QNAN, fp_class_e enum (NORMAL, ZERO, INF, NAN).
- One natural sub-module: fp_round_rne (combinational; mant, g, s, e in -> rounded mant, e out). Reusable by the adder's normalize stage.

Test Plan:
- 1.0*1.0: prod = 48'h400000000000, exp = 127, out_ready = 1 -> out_result = 32'h3F800000 exactly 2 cycles later; all flags 0.
- 1.5*1.5: prod = 48'h900000000000, exp = 127 -> 32'h40100000.
- Rounding:
  - prod = 48'h400000400000 (tie, lsb 0) -> 32'h3F800000 with inexact = 1.
  - prod = 48'h400000C00000 (tie, lsb 1) -> 32'h3F800002.
  - prod = 48'h7FFFFFC00000 -> mantissa carry -> 32'h40000000.
- Overflow/underflow:
  - exp = 254, prod = 48'h800000000000, sign 0 -> 32'h7F800000, overflow = 1.
  - exp = 0, prod = 48'h400000000000, sign 1 -> 32'h80000000, underflow = 1.
- Specials:
  - in_is_nan = 1 together with in_is_inf = 1 -> 32'h7FC00000.
  - in_is_zero = 1, sign 1 -> 32'h80000000, flags 0.
- Backpressure/reset:
  - Offer 3 back-to-back inputs with out_ready = 0 -> exactly 2 accepted, in_ready = 0 afterwards, out_result stable.
  - Raise out_ready -> results emerge in order, then the third is accepted.
  - Repeat, asserting rst mid-stall -> out_valid = 0 the next cycle and no stale result appears.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP32 types and constants for the floating-point datapath blocks.
package fpu_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP32_BIAS    = 127;
    localparam int          FP32_EXP_MAX = 255;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ZERO   = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard/sticky bits.
// A carry out of the fraction wraps it to zero and bumps the exponent.
module fp_round_rne #(
    parameter int EXP_W = 11
) (
    input  logic [22:0]             mant,
    input  logic                    g,
    input  logic                    s,
    input  logic signed [EXP_W-1:0] e,
    output logic [22:0]             mant_rnd,
    output logic signed [EXP_W-1:0] e_rnd
);

    // Returns {carry, fraction} after the optional increment.
    function automatic logic [23:0] rne_inc(input logic [22:0] m, input logic gb, input logic sb);
        logic up;
        up = gb & (sb | m[0]);
        return {1'b0, m} + {23'b0, up};
    endfunction

    logic [23:0] sum;
    logic        carry;

    assign sum      = rne_inc(mant, g, s);
    assign carry    = sum[23];
    assign mant_rnd = sum[22:0];
    assign e_rnd    = e + EXP_W'(carry);

endmodule

// File: rtl/fp32_mul_round.sv
// Back end of the FP32 multiplier: normalizes the 48-bit significand
// product, rounds to nearest-even, flushes underflow to zero, saturates
// overflow to infinity, resolves special operands and packs the result.
// Two pipeline stages with valid/ready on both sides.
module fp32_mul_round
    import fpu_pkg::*;
#(
    parameter int          IN_EXP_W  = 10,
    parameter logic [31:0] NAN_CANON = FP32_QNAN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sign,
    input  logic signed [IN_EXP_W-1:0] in_exp,
    input  logic [47:0]                in_prod,
    input  logic                       in_is_nan,
    input  logic                       in_is_inf,
    input  logic                       in_is_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic                       out_overflow,
    output logic                       out_underflow,
    output logic                       out_inexact
);

    localparam int E_W = IN_EXP_W + 1;
    localparam logic signed [E_W-1:0] EMAX = E_W'(FP32_EXP_MAX);

    // Post-rounding exponent saturation tests.
    function automatic logic exp_ovf(input logic signed [E_W-1:0] e);
        return e >= EMAX;
    endfunction

    function automatic logic exp_unf(input logic signed [E_W-1:0] e);
        return e[E_W-1] | (e == '0);
    endfunction

    function automatic logic [31:0] pack(input logic sign, input logic [7:0] exp, input logic [22:0] frac);
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.frac = frac;
        return f;
    endfunction

    // Handshake: each stage advances when it is empty or its consumer drains it.
    logic vld_p1;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !vld_p1 | s2_adv;
    assign in_ready = s1_adv;

    // ---- stage 0 -> 1: normalize ----
    logic                 sign_d;
    logic [22:0]          mant_d;
    logic                 g_d;
    logic                 s_d;
    logic signed [E_W-1:0] e_d;
    fp_class_e            cls_d;

    // Select the normalization shift and classify the operand.
    always_comb begin
        sign_d = in_sign;
        if (in_prod[47]) begin
            mant_d = in_prod[46:24];
            g_d    = in_prod[23];
            s_d    = |in_prod[22:0];
        end else begin
            mant_d = in_prod[45:23];
            g_d    = in_prod[22];
            s_d    = |in_prod[21:0];
        end
        e_d = {in_exp[IN_EXP_W-1], in_exp} + E_W'(in_prod[47]);
        if (in_is_nan)
            cls_d = NAN;
        else if (in_is_inf)
            cls_d = INF;
        else if (in_is_zero || in_prod[47:46] == 2'b00)
            cls_d = ZERO;
        else
            cls_d = NORMAL;
    end

    logic                  sign_p1;
    logic [22:0]           mant_p1;
    logic                  g_p1;
    logic                  s_p1;
    logic signed [E_W-1:0] e_p1;
    fp_class_e             cls_p1;

    // Stage-1 valid flag.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (s1_adv)
            vld_p1 <= in_valid;
    end

    // Stage-1 datapath register.
    always_ff @(posedge clk) begin
        if (s1_adv) begin
            sign_p1 <= sign_d;
            mant_p1 <= mant_d;
            g_p1    <= g_d;
            s_p1    <= s_d;
            e_p1    <= e_d;
            cls_p1  <= cls_d;
        end
    end

    // ---- stage 1 -> 2: round and pack ----
    logic [22:0]           mant_r;
    logic signed [E_W-1:0] e_r;

    fp_round_rne #(
        .EXP_W(E_W)
    ) u_round (
        .mant    (mant_p1),
        .g       (g_p1),
        .s       (s_p1),
        .e       (e_p1),
        .mant_rnd(mant_r),
        .e_rnd   (e_r)
    );

    logic [31:0] res_d;
    logic        ovf_d;
    logic        unf_d;
    logic        inx_d;

    // Resolve specials, saturate and pack.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        case (cls_p1)
            NAN:  res_d = NAN_CANON;
            INF:  res_d = pack(sign_p1, 8'hFF, 23'b0);
            ZERO: res_d = pack(sign_p1, 8'h00, 23'b0);
            default: begin
                if (exp_ovf(e_r)) begin
                    res_d = pack(sign_p1, 8'hFF, 23'b0);
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (exp_unf(e_r)) begin
                    res_d = pack(sign_p1, 8'h00, 23'b0);
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    res_d = pack(sign_p1, e_r[7:0], mant_r);
                    inx_d = g_p1 | s_p1;
                end
            end
        endcase
    end

    // Output register; held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_adv) begin
            out_valid     <= vld_p1;
            out_result    <= res_d;
            out_overflow  <= ovf_d;
            out_underflow <= unf_d;
            out_inexact   <= inx_d;
        end
    end

endmodule

// File: tb/tb_fp32_mul_round.sv
// Scoreboard bench for fp32_mul_round: directed vectors with hand-computed results.
module tb_fp32_mul_round;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic signed [9:0]  in_exp;
    logic [47:0]        in_prod;
    logic               in_is_nan;
    logic               in_is_inf;
    logic               in_is_zero;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic               out_overflow;
    logic               out_underflow;
    logic               out_inexact;

    always #5 clk = ~clk;

    fp32_mul_round dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_prod      (in_prod),
        .in_is_nan    (in_is_nan),
        .in_is_inf    (in_is_inf),
        .in_is_zero   (in_is_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_inexact  (out_inexact)
    );

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] prod;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mexp;
    vec_t vecs[15];
    vec_t bp[3];

    function automatic vec_t mk(input logic sg, input logic [9:0] ex, input logic [47:0] pr,
                                input logic na, input logic in, input logic ze,
                                input logic [31:0] r, input logic o, input logic u, input logic x);
        vec_t v;
        v.sign = sg; v.exp = ex; v.prod = pr; v.nan = na; v.inf = in; v.zero = ze;
        v.res = r; v.ovf = o; v.unf = u; v.inx = x;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        in_sign    = v.sign;
        in_exp     = v.exp;
        in_prod    = v.prod;
        in_is_nan  = v.nan;
        in_is_inf  = v.inf;
        in_is_zero = v.zero;
        in_valid   = 1'b1;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.inx = v.inx;
        sb.push_back(e);
    endtask

    task automatic send(input vec_t v);
        logic ok;
        ok = 1'b0;
        drive(v);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push(v);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never rose for result %h", v.res);
        end
    endtask

    // Monitor: every transfer on the output side is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing expected", out_result);
                end else begin
                    mexp = sb.pop_front();
                    if ({out_result, out_overflow, out_underflow, out_inexact} !==
                        {mexp.res, mexp.ovf, mexp.unf, mexp.inx}) begin
                        errors++;
                        $display("FAIL result: got %h ovf=%b unf=%b inx=%b expected %h ovf=%b unf=%b inx=%b",
                                 out_result, out_overflow, out_underflow, out_inexact,
                                 mexp.res, mexp.ovf, mexp.unf, mexp.inx);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int     acc;
        logic [31:0] held;

        vecs[0]  = mk(0, 10'd127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 0, 0, 0);
        vecs[1]  = mk(0, 10'd127, 48'h900000000000, 0, 0, 0, 32'h40100000, 0, 0, 0);
        vecs[2]  = mk(0, 10'd127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 0, 0, 1);
        vecs[3]  = mk(0, 10'd127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 0, 0, 1);
        vecs[4]  = mk(0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 0, 0, 1);
        vecs[5]  = mk(0, 10'd254, 48'h800000000000, 0, 0, 0, 32'h7F800000, 1, 0, 1);
        vecs[6]  = mk(1, 10'd0,   48'h400000000000, 0, 0, 0, 32'h80000000, 0, 1, 1);
        vecs[7]  = mk(0, 10'd127, 48'h400000000000, 1, 1, 0, 32'h7FC00000, 0, 0, 0);
        vecs[8]  = mk(1, 10'd127, 48'h000000000000, 0, 0, 1, 32'h80000000, 0, 0, 0);
        vecs[9]  = mk(1, 10'd127, 48'h000000000000, 0, 1, 0, 32'hFF800000, 0, 0, 0);
        vecs[10] = mk(0, 10'd127, 48'h200000000000, 0, 0, 0, 32'h00000000, 0, 0, 0);
        vecs[11] = mk(0, 10'h3FB, 48'h400000000000, 0, 0, 0, 32'h00000000, 0, 1, 1);
        vecs[12] = mk(1, 10'd254, 48'h400000000000, 0, 0, 0, 32'hFF000000, 0, 0, 0);
        vecs[13] = mk(0, 10'd127, 48'h400000000001, 0, 0, 0, 32'h3F800000, 0, 0, 1);
        vecs[14] = mk(0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 1, 0, 1);
        bp[0] = vecs[1];
        bp[1] = vecs[4];
        bp[2] = vecs[9];

        rst = 1'b1;
        in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
        in_is_nan = 1'b0; in_is_inf = 1'b0; in_is_zero = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_result", out_result, 32'h0);
        chk("reset_flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Latency of the first result with out_ready held high.
        send(vecs[0]);
        chk("latency_stage1_not_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("latency_out_result", out_result, 32'h3F800000);

        // Main vectors, back to back.
        for (int i = 1; i < 15; i++) send(vecs[i]);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: three offered, two accepted.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (acc < 3) drive(bp[acc]);
            @(negedge clk);
            if (in_ready && acc < 3) begin
                push(bp[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        held = out_result;
        chk("bp_head_result", held, 32'h40100000);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_result_stable", out_result, held);
        chk("bp_valid_held", 32'(out_valid), 32'd1);

        // Release: queued results drain in order, then the third is accepted.
        out_ready = 1'b1;
        if (acc < 3) begin
            send(bp[acc]);
            acc++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Reset while stalled discards everything in flight.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 2; c++) begin
            drive(bp[c]);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("rst_stall_accepted", 32'(acc), 32'd2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_result", out_result, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_stale_valid", 32'(out_valid), 32'd0);

        // Recovery after reset.
        send(vecs[3]);
        repeat (4) @(posedge clk);
        #1;
        chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
